// File: rtl/accel_job_master.sv
// rtl/accel_job_master.sv - accelerator job bus master; optional poll timeout via ACCEL_JOB_TIMEOUT_EN
module accel_job_master #(
    parameter int                        INT_ADDR_WIDTH = 20,
    parameter int                        DATA_WIDTH     = 32,
    parameter logic [INT_ADDR_WIDTH-1:0] CTRL_ADDR      = 'h0,
    parameter logic [INT_ADDR_WIDTH-1:0] STAT_ADDR      = 'h8,
    parameter logic [INT_ADDR_WIDTH-1:0] OUT_OFFSET     = 'h100,
    parameter int                        MAX_IN_WORDS   = 64,
    parameter int                        TIMEOUT_CYCLES = 4096
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               job_valid,
    output logic                               job_ready,
    input  logic [$clog2(MAX_IN_WORDS+1)-1:0]  job_n_in,
    input  logic [5:0]                         job_out_len,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               job_done,
    output logic                               job_err,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [INT_ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH/8-1:0]            mem_be,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    input  logic [DATA_WIDTH-1:0]              mem_rdata
);

    localparam int CW  = $clog2(MAX_IN_WORDS + 1);
    localparam int BW  = DATA_WIDTH / 8;
    localparam int BSH = $clog2(BW);
    // Address MSB set selects accelerator data memory
    localparam logic [INT_ADDR_WIDTH-1:0] DATA_BASE = {1'b1, {(INT_ADDR_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, WR_IN, START, POLL, POLL_WAIT, RD, RD_WAIT, FIN
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              n_in_q, n_in_d;
    logic [CW-1:0]              n_out_q, n_out_d;
    logic [5:0]                 out_len_q, out_len_d;
    logic                       out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;

    logic [6:0]                 n_out_calc;
    logic [INT_ADDR_WIDTH-1:0]  word_off;

`ifdef ACCEL_JOB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] poll_cnt_q, poll_cnt_d;
    logic          err_q, err_d;
`endif

    // Result word count is the byte length rounded up to whole bus words
    assign n_out_calc = ({1'b0, job_out_len} + 7'(BW - 1)) >> BSH;
    assign word_off   = INT_ADDR_WIDTH'(idx_q) << BSH;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef ACCEL_JOB_TIMEOUT_EN
    assign job_err = (state_q == FIN) && err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign job_err = 1'b0;
`endif

    // Next-state, bus request and handshake outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_in_d      = n_in_q;
        n_out_d     = n_out_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        job_ready   = 1'b0;
        in_ready    = 1'b0;
        job_done    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = '0;
        mem_wdata   = '0;
`ifdef ACCEL_JOB_TIMEOUT_EN
        poll_cnt_d  = poll_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    n_in_d    = job_n_in;
                    out_len_d = job_out_len;
                    n_out_d   = CW'(n_out_calc);
                    idx_d     = '0;
                    state_d   = (job_n_in == '0) ? START : WR_IN;
`ifdef ACCEL_JOB_TIMEOUT_EN
                    poll_cnt_d = '0;
                    err_d      = 1'b0;
`endif
                end
            end
            WR_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_be    = '1;
                    mem_addr  = DATA_BASE + word_off;
                    mem_wdata = in_data;
                    if (idx_q + CW'(1) == n_in_q) begin
                        idx_d   = '0;
                        state_d = START;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            START: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_be    = '1;
                mem_addr  = CTRL_ADDR;
                mem_wdata = DATA_WIDTH'({out_len_q, 7'b0, 1'b1});
                state_d   = POLL;
            end
            POLL: begin
                mem_req  = 1'b1;
                mem_addr = STAT_ADDR;
                state_d  = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (mem_rdata[8]) begin
                    idx_d   = '0;
                    state_d = (n_out_q == '0) ? FIN : RD;
                end else begin
                    state_d = POLL;
                end
            end
            RD: begin
                // Only fetch when the output register is free, so a stalled
                // consumer never causes a read whose data would be lost
                if (out_valid_q) begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (idx_q + CW'(1) == n_out_q) begin
                            idx_d   = '0;
                            state_d = FIN;
                        end else begin
                            idx_d = idx_q + CW'(1);
                        end
                    end
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = DATA_BASE + OUT_OFFSET + word_off;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                out_data_d  = mem_rdata;
                out_valid_d = 1'b1;
                state_d     = RD;
            end
            FIN: begin
                job_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef ACCEL_JOB_TIMEOUT_EN
        // Give up on a slave that never reports done; a done seen on the
        // final poll cycle still wins over the timeout
        if (state_q == POLL || state_q == POLL_WAIT) begin
            poll_cnt_d = poll_cnt_q + TW'(1);
            if (poll_cnt_q == TW'(TIMEOUT_CYCLES - 1) &&
                !(state_q == POLL_WAIT && mem_rdata[8])) begin
                state_d = FIN;
                err_d   = 1'b1;
            end
        end
`endif
    end

    // State and datapath registers; reset abandons any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            n_in_q      <= '0;
            n_out_q     <= '0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`ifdef ACCEL_JOB_TIMEOUT_EN
            poll_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_in_q      <= n_in_d;
            n_out_q     <= n_out_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef ACCEL_JOB_TIMEOUT_EN
            poll_cnt_q  <= poll_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_accel_job_master.sv
// tb/tb_accel_job_master.sv - self-checking bench for accel_job_master
module tb_accel_job_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid, job_ready;
    logic [6:0]  job_n_in;
    logic [5:0]  job_out_len;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        job_done, job_err;
    logic        mem_req, mem_we;
    logic [19:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    accel_job_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_n_in(job_n_in), .job_out_len(job_out_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .job_done(job_done), .job_err(job_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [19:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        int          n_in;
        int          out_len;
        int          done_after;
        int          in_gap;
        int          out_gap;
        int          hold;
        logic [31:0] exp_ctrl;
        int          exp_nout;
    } vec_t;

    int          n_pass = 0;
    int          n_chk = 0;
    bus_t        bus_log[$];
    logic [31:0] out_log[$];
    int          polls_seen = 0;
    int          done_after = 0;
    logic [31:0] res_seed = 32'h1;
    int          viol, done_cnt, err_cnt, holding, hold_reads;
    logic        prev_ov = 1'b0, prev_or = 1'b0;
    logic [31:0] prev_od = '0;

    function automatic logic [31:0] res_word(input logic [19:0] a, input logic [31:0] s);
        return (s * 32'h9E3779B1) ^ {12'h0, a} ^ ({12'h0, a} << 13);
    endfunction

    // Slave: status word reports done from the configured poll onward, with
    // noise in the other bits; result region is a pure function of address
    always @(posedge clk) begin
        if (mem_req && !mem_we) begin
            if (mem_addr == 20'h8)
                mem_rdata <= ($urandom & ~32'h100) |
                             ((done_after != 0 && polls_seen >= done_after) ? 32'h100 : 32'h0);
            else
                mem_rdata <= res_word(mem_addr, res_seed);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic sample();
        if (mem_req) begin
            bus_log.push_back('{mem_addr, mem_we, mem_be, mem_wdata});
            if (!mem_we && mem_addr == 20'h8) polls_seen++;
            if (!mem_we && (mem_be != 0 || mem_wdata != 0)) viol++;
            if (holding != 0 && !mem_we && mem_addr != 20'h8) hold_reads++;
        end else if (mem_we || mem_be != 0 || mem_wdata != 0) begin
            viol++;
        end
        if (prev_ov && !prev_or && (!out_valid || out_data !== prev_od)) viol++;
        if (out_valid && out_ready) out_log.push_back(out_data);
        if (job_done) done_cnt++;
        if (job_err) err_cnt++;
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_od = out_data;
    endtask

    task automatic run_job(input int n_in, input int out_len, input int da,
                           input int in_gap, input int out_gap, input int hold);
        logic [31:0] words[$];
        bus_t        exp_bus[$];
        logic [31:0] exp_out[$];
        int          in_idx = 0;
        int          hold_left = hold;
        int          cyc = 0;
        int          n_out, np, nb, no;
        bit          fin = 0;
        bus_log.delete();
        out_log.delete();
        polls_seen = 0;
        done_after = da;
        res_seed   = $urandom;
        viol = 0; done_cnt = 0; err_cnt = 0; hold_reads = 0; holding = 0;
        for (int k = 0; k < n_in; k++) words.push_back($urandom);

        @(negedge clk);
        job_valid = 1'b1; job_n_in = 7'(n_in); job_out_len = 6'(out_len);
        in_valid = 1'b0; out_ready = 1'b0;
        #1; sample();
        chk("job_ready_idle", job_ready, 1);
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            job_valid   = 1'b0;
            job_n_in    = 7'($urandom);
            job_out_len = 6'($urandom);
            in_valid    = ($urandom_range(99) >= in_gap);
            in_data     = (in_idx < n_in) ? words[in_idx] : $urandom;
            if (hold_left > 0 && out_valid) begin
                out_ready = 1'b0; hold_left--; holding = 1;
            end else begin
                holding = 0;
                out_ready = ($urandom_range(99) >= out_gap);
            end
            #1;
            if (in_valid && in_ready) in_idx++;
            sample();
            if (job_done) fin = 1;
            cyc++;
        end
        chk("job_done_seen", fin, 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; holding = 0;
        #1; sample();
        chk("done_one_cycle", job_done, 0);
        chk("ready_after_fin", job_ready, 1);

        // Reference: the bus transactions a job must produce, derived directly
        n_out = (out_len + 3) / 4;
        np = (da == 0) ? TO / 2 : da;
        for (int k = 0; k < n_in; k++) exp_bus.push_back('{20'h80000 + 20'(4 * k), 1'b1, 4'hF, words[k]});
        exp_bus.push_back('{20'h0, 1'b1, 4'hF, (32'(out_len) << 8) | 32'h1});
        for (int p = 0; p < np; p++) exp_bus.push_back('{20'h8, 1'b0, 4'h0, 32'h0});
        if (da != 0) begin
            for (int k = 0; k < n_out; k++) begin
                exp_bus.push_back('{20'h80100 + 20'(4 * k), 1'b0, 4'h0, 32'h0});
                exp_out.push_back(res_word(20'h80100 + 20'(4 * k), res_seed));
            end
        end
        chk("bus_count", bus_log.size(), exp_bus.size());
        nb = (bus_log.size() < exp_bus.size()) ? bus_log.size() : exp_bus.size();
        for (int i = 0; i < nb; i++)
            chk($sformatf("bus[%0d]", i),
                {7'h0, bus_log[i].addr, bus_log[i].we, bus_log[i].be, bus_log[i].wdata},
                {7'h0, exp_bus[i].addr, exp_bus[i].we, exp_bus[i].be, exp_bus[i].wdata});
        chk("out_count", out_log.size(), exp_out.size());
        no = (out_log.size() < exp_out.size()) ? out_log.size() : exp_out.size();
        for (int i = 0; i < no; i++) chk($sformatf("out[%0d]", i), out_log[i], exp_out[i]);
        chk("done_pulses", done_cnt, 1);
        chk("err_pulses", err_cnt, (da == 0) ? 1 : 0);
        chk("protocol_viol", viol, 0);
        chk("inputs_consumed", in_idx, n_in);
        if (hold > 0) chk("reads_while_held", hold_reads, 0);
    endtask

    vec_t        vecs[$];
    logic [31:0] ctrl_obs;
    int          rd_obs, quiet;

    initial begin
        job_valid = 0; job_n_in = 0; job_out_len = 0;
        in_valid = 0; in_data = 0; out_ready = 0;

        vecs.push_back('{3,  8,  2, 0,  0,  0,  32'h0000_0801, 2});
        vecs.push_back('{0,  0,  1, 0,  0,  0,  32'h0000_0001, 0});
        vecs.push_back('{5,  5,  1, 0,  0,  10, 32'h0000_0501, 2});
        vecs.push_back('{6,  63, 3, 50, 30, 0,  32'h0000_3F01, 16});
        vecs.push_back('{64, 1,  1, 20, 0,  0,  32'h0000_0101, 1});
        vecs.push_back('{1,  4,  1, 0,  0,  0,  32'h0000_0401, 1});

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", job_ready, 1);
        chk("reset_outs", {mem_req, mem_we, mem_be, in_ready, out_valid, job_done, job_err}, 0);
        chk("reset_bus", {mem_addr, mem_wdata}, 0);
        rst_n = 1'b1;

        foreach (vecs[v]) begin
            run_job(vecs[v].n_in, vecs[v].out_len, vecs[v].done_after,
                    vecs[v].in_gap, vecs[v].out_gap, vecs[v].hold);
            ctrl_obs = '0; rd_obs = 0;
            foreach (bus_log[i]) begin
                if (bus_log[i].we && bus_log[i].addr == 20'h0) ctrl_obs = bus_log[i].wdata;
                if (!bus_log[i].we && bus_log[i].addr != 20'h8) rd_obs++;
            end
            chk($sformatf("vec%0d_ctrl", v), ctrl_obs, vecs[v].exp_ctrl);
            chk($sformatf("vec%0d_nreads", v), rd_obs, vecs[v].exp_nout);
        end

        for (int r = 0; r < 20; r++)
            run_job(($urandom_range(3) == 0) ? 0 : $urandom_range(64), $urandom_range(63),
                    $urandom_range(1, 4), $urandom_range(0, 60), $urandom_range(0, 60), 0);

`ifdef ACCEL_JOB_TIMEOUT_EN
        run_job(2, 8, 0, 0, 0, 0);
`endif

        // Reset while polling a slave that never finishes
        bus_log.delete(); polls_seen = 0; done_after = 0; holding = 0;
        @(negedge clk);
        job_valid = 1'b1; job_n_in = 7'd1; job_out_len = 6'd4;
        #1; sample();
        for (int c = 0; c < 50 && polls_seen < 2; c++) begin
            @(negedge clk);
            job_valid = 1'b0; in_valid = 1'b1; in_data = $urandom; out_ready = 1'b1;
            #1; sample();
        end
        chk("reached_poll", (polls_seen >= 2) ? 1 : 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", job_ready, 1);
        chk("rst_outs", {mem_req, mem_we, mem_be, in_ready, out_valid, job_done, job_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = $urandom_range(1); out_ready = $urandom_range(1);
            #1;
            if (mem_req) quiet++;
        end
        chk("bus_quiet_after_reset", quiet, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/accel_job_master.md
# accel_job_master

Memory-bus initiator that runs one accelerator job end to end over the accelerator's internal single-port bus (req/addr/we/be/wdata/rdata, one-cycle read latency). It streams input words into accelerator data memory, writes the control word with the start bit and output length, polls the status word until done, then streams the result words out. It sits between a host-side job/stream source and the address-split config/data memory of the accelerator top wrapper, as the bus master driving that slave port.

## Interface
Parameters:
- INT_ADDR_WIDTH, 20, bus byte-address width; MSB=1 selects data memory, MSB=0 selects config registers
- DATA_WIDTH, 32, bus and stream word width
- CTRL_ADDR, 'h0, byte address of control word 0
- STAT_ADDR, 'h8, byte address of status word 0
- OUT_OFFSET, 'h100, byte offset of the result region inside data memory
- MAX_IN_WORDS, 64, maximum input words per job
- TIMEOUT_CYCLES, 4096, poll timeout (only with the timeout macro)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_n_in  in  $clog2(MAX_IN_WORDS+1)  input word count (0 allowed)
- job_out_len  in  6  output length in bytes (0..63)
- in_valid / in_ready  in / out  1 / 1  input word handshake
- in_data  in  DATA_WIDTH  input word
- out_valid / out_ready  out / in  1 / 1  result word handshake
- out_data  out  DATA_WIDTH  result word
- job_done  out  1  one-cycle pulse at job end
- job_err  out  1  one-cycle pulse with job_done on timeout, else 0
- mem_req, mem_we  out  1  bus request, write enable
- mem_addr  out  INT_ADDR_WIDTH  word-aligned byte address
- mem_be  out  DATA_WIDTH/8  byte enables
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after a read request

## Operation
- States: IDLE, WR_IN, START, POLL, POLL_WAIT, RD, RD_WAIT, FIN.
- IDLE: job_ready=1; on job_valid latch job_n_in, job_out_len; go WR_IN (or START if job_n_in=0).
- WR_IN: in_ready=1; each accepted word issues a write same cycle: addr = DATA_BASE + 4*k, be all ones, k=0..n_in-1. After last word go START.
- START: one write to CTRL_ADDR, wdata = {18'b0, out_len, 7'b0, 1'b1}, be all ones; go POLL.
- POLL: read STAT_ADDR; POLL_WAIT samples mem_rdata[8] (done). done=1 → RD; else back to POLL (one poll per two cycles).
- Result word count n_out = ceil(out_len/4) (DATA_WIDTH=32: (out_len+3)>>2). n_out=0 → FIN directly.
- RD: issue read at DATA_BASE + OUT_OFFSET + 4*k only when output register empty; RD_WAIT captures mem_rdata into out_data, out_valid=1. After out handshake of word n_out-1 go FIN.
- FIN: job_done=1 for one cycle; return IDLE. Start-bit clearing is the slave's responsibility; this block never writes control again.
- Bus: mem_req high exactly one cycle per access; no back-to-back dependency on grant (slave always accepts). mem_we=0, mem_be=0, mem_wdata=0 on reads and idle.
- Address arithmetic modulo 2^INT_ADDR_WIDTH; word index counters saturate-free, width $clog2(MAX_IN_WORDS+1).

## Timing
- Reset: state IDLE, all outputs 0 except job_ready=1; counters cleared. Reset mid-job abandons the job with no further bus traffic.
- job accept → first bus cycle: 1 cycle.
- Input write latency: 0 (write on the in handshake cycle).
- Read: request cycle N, data registered to out_data at N+1, out_valid from N+1 until out_ready.
- out_valid and out_data stable while out_valid && !out_ready.
- job_valid ignored outside IDLE; in_valid ignored outside WR_IN.

## Configuration
- ACCEL_JOB_TIMEOUT_EN defined: poll counter counts POLL/POLL_WAIT cycles; on reaching TIMEOUT_CYCLES without done go FIN with job_err=1 and no result reads.
- Undefined: poll indefinitely; job_err tied 0; no counter.

## Test plan
- job_n_in=3, out_len=8, words A,B,C; slave done on 2nd poll → writes at 0x80000,0x80004,0x80008, control write 0x0000_0801, two reads at 0x80100/0x80104, two out words, job_done pulse.
- job_n_in=0, out_len=0, done on first poll → only control write 0x0000_0001 and one status read, then job_done.
- out_len=5 → n_out=2; hold out_ready=0 for 10 cycles → no second read issued, out_data stable.
- in_valid gaps (toggling) during WR_IN → writes only on handshake cycles, addresses contiguous.
- With ACCEL_JOB_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never set → job_done and job_err pulse together after 16 poll cycles, no data reads.
- Assert rst_n low during POLL → all outputs reset immediately, job_ready=1, no bus activity after release.
